// File: rtl/pool_window_gen_if.sv
// Pixel-stream and dual-rail window bundle between the pixel source, pool_window_gen and the 2x2 max-pool kernel.
interface pool_window_gen_if #(
    parameter int unsigned BIT_DATA = 8
);
    logic                in_valid;
    logic                in_ready;
    logic [BIT_DATA-1:0] in_data;
    logic [BIT_DATA-1:0] x0_t, x0_f;
    logic [BIT_DATA-1:0] x1_t, x1_f;
    logic [BIT_DATA-1:0] x2_t, x2_f;
    logic [BIT_DATA-1:0] x3_t, x3_f;
    logic                ack_nxt;
    logic                frame_done;

    modport master (
        output in_valid, in_data, ack_nxt,
        input  in_ready, frame_done,
        input  x0_t, x0_f, x1_t, x1_f, x2_t, x2_f, x3_t, x3_f
    );

    modport slave (
        input  in_valid, in_data, ack_nxt,
        output in_ready, frame_done,
        output x0_t, x0_f, x1_t, x1_f, x2_t, x2_f, x3_t, x3_f
    );
endinterface

// File: rtl/pool_window_gen.sv
// Raster pixel stream -> stride-2 2x2 windows on dual-rail, four-phase RTZ outputs.
// Optional macro POOL_PAD_EN: odd IMG_W pads the last column pair with the most negative value.
module pool_window_gen #(
    parameter int unsigned BIT_DATA = 8,
    parameter int unsigned IMG_W    = 16,
    parameter int unsigned IMG_H    = 16
) (
    input  logic              clk,
    input  logic              reset,
    pool_window_gen_if.slave  bus
);
    localparam int unsigned CW = (IMG_W > 1) ? $clog2(IMG_W) : 1;
    localparam int unsigned RW = (IMG_H > 1) ? $clog2(IMG_H) : 1;
`ifdef POOL_PAD_EN
    localparam bit PAD_EN = 1'b1;
`else
    localparam bit PAD_EN = 1'b0;
`endif
    localparam bit          PAD_COL  = PAD_EN && ((IMG_W % 2) == 1);
    localparam int unsigned LAST_ROW = (IMG_H / 2) * 2 - 1;
    localparam int unsigned LAST_COL = PAD_COL ? (IMG_W - 1) : ((IMG_W / 2) * 2 - 1);

    typedef logic [BIT_DATA-1:0] word_t;
    typedef word_t [3:0]         win_t;
    typedef enum logic [1:0] {ST_IDLE, ST_DATA, ST_NULL} state_t;

    localparam word_t MOST_NEG = {1'b1, {(BIT_DATA-1){1'b0}}};

    state_t        state_q, state_d;
    logic [CW-1:0] col_q, col_d;
    logic [RW-1:0] row_q, row_d;
    word_t         line_q [IMG_W];
    word_t         line_d [IMG_W];
    word_t         held_q, held_d;
    win_t          rail_t_q, rail_t_d;
    win_t          rail_f_q, rail_f_d;
    logic          last_q, last_d;
    logic          ack_meta_q, ack_meta_d;
    logic          ack_s_q, ack_s_d;
    logic          in_ready_q, in_ready_d;
    logic          frame_done_q, frame_done_d;

    logic          accept_c;
    logic          win_done_c;
    logic          pad_c;
    logic [CW-1:0] pair_col_c;
    win_t          win_c;

    // A pixel completes a window on odd rows at odd columns, or at the padded last column.
    function automatic logic completes(input logic [CW-1:0] c, input logic [RW-1:0] r);
        return r[0] && (c[0] || (PAD_COL && (c == CW'(IMG_W - 1))));
    endfunction

    always_comb begin
        state_d      = state_q;
        col_d        = col_q;
        row_d        = row_q;
        line_d       = line_q;
        held_d       = held_q;
        rail_t_d     = rail_t_q;
        rail_f_d     = rail_f_q;
        last_d       = last_q;
        frame_done_d = 1'b0;
        ack_meta_d   = bus.ack_nxt;
        ack_s_d      = ack_meta_q;

        accept_c   = bus.in_valid && in_ready_q;
        win_done_c = accept_c && completes(col_q, row_q);
        pad_c      = PAD_COL && !col_q[0];
        // Clearing bit 0 gives col-1 for odd columns and col itself for the padded even column.
        pair_col_c = col_q & ~CW'(1);
        win_c[0]   = line_q[pair_col_c];
        win_c[1]   = pad_c ? MOST_NEG : line_q[col_q];
        win_c[2]   = pad_c ? bus.in_data : held_q;
        win_c[3]   = pad_c ? MOST_NEG : bus.in_data;

        if (accept_c) begin
            if (!row_q[0]) begin
                line_d[col_q] = bus.in_data;
            end else if (!col_q[0]) begin
                held_d = bus.in_data;
            end
            if (col_q == CW'(IMG_W - 1)) begin
                col_d = '0;
                row_d = (row_q == RW'(IMG_H - 1)) ? '0 : RW'(row_q + RW'(1));
            end else begin
                col_d = CW'(col_q + CW'(1));
            end
        end

        case (state_q)
            ST_IDLE: begin
                if (win_done_c) begin
                    rail_t_d = win_c;
                    rail_f_d = ~win_c;
                    last_d   = (row_q == RW'(LAST_ROW)) && (col_q == CW'(LAST_COL));
                    state_d  = ST_DATA;
                end
            end
            ST_DATA: begin
                if (ack_s_q) begin
                    rail_t_d = '0;
                    rail_f_d = '0;
                    state_d  = ST_NULL;
                end
            end
            ST_NULL: begin
                if (!ack_s_q) begin
                    frame_done_d = last_q;
                    state_d      = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase

        // Only a window-completing pixel must wait for the handshake to return to IDLE.
        in_ready_d = (state_d == ST_IDLE) || !completes(col_d, row_d);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q      <= ST_IDLE;
            col_q        <= '0;
            row_q        <= '0;
            rail_t_q     <= '0;
            rail_f_q     <= '0;
            last_q       <= 1'b0;
            ack_meta_q   <= 1'b0;
            ack_s_q      <= 1'b0;
            in_ready_q   <= 1'b0;
            frame_done_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            col_q        <= col_d;
            row_q        <= row_d;
            rail_t_q     <= rail_t_d;
            rail_f_q     <= rail_f_d;
            last_q       <= last_d;
            ack_meta_q   <= ack_meta_d;
            ack_s_q      <= ack_s_d;
            in_ready_q   <= in_ready_d;
            frame_done_q <= frame_done_d;
        end
    end

    // Pixel storage carries no control meaning, so it is left out of reset.
    always_ff @(posedge clk) begin
        line_q <= line_d;
        held_q <= held_d;
    end

    assign bus.in_ready   = in_ready_q;
    assign bus.frame_done = frame_done_q;
    assign bus.x0_t       = rail_t_q[0];
    assign bus.x0_f       = rail_f_q[0];
    assign bus.x1_t       = rail_t_q[1];
    assign bus.x1_f       = rail_f_q[1];
    assign bus.x2_t       = rail_t_q[2];
    assign bus.x2_f       = rail_f_q[2];
    assign bus.x3_t       = rail_t_q[3];
    assign bus.x3_f       = rail_f_q[3];
endmodule

// File: tb/tb_pool_window_gen.sv
// Directed bench for pool_window_gen: a 4x2 instance and a 5x3 instance, each with a delayed-ack kernel model.
module tb_pool_window_gen;
    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic tb_rst;
    int   errors = 0;
    int   checks = 0;

    pool_window_gen_if #(.BIT_DATA(8)) ba ();
    pool_window_gen_if #(.BIT_DATA(8)) bb ();

    pool_window_gen #(.BIT_DATA(8), .IMG_W(4), .IMG_H(2)) dut_a (.clk(clk), .reset(tb_rst), .bus(ba));
    pool_window_gen #(.BIT_DATA(8), .IMG_W(5), .IMG_H(3)) dut_b (.clk(clk), .reset(tb_rst), .bus(bb));

    bit          a_hold = 1'b0, b_hold = 1'b0;
    int          a_cnt = 0, b_cnt = 0, a_done = 0, b_done = 0;
    logic [31:0] a_t[$], a_f[$], b_t[$], b_f[$];

    wire a_present = |{ba.x0_t, ba.x0_f, ba.x1_t, ba.x1_f, ba.x2_t, ba.x2_f, ba.x3_t, ba.x3_f};
    wire b_present = |{bb.x0_t, bb.x0_f, bb.x1_t, bb.x1_f, bb.x2_t, bb.x2_f, bb.x3_t, bb.x3_f};

    // Kernel model A: ack 3 cycles after data appears, release 3 cycles after spacer.
    always @(negedge clk) begin
        if (tb_rst) begin
            ba.ack_nxt = 1'b0;
            a_cnt      = 0;
        end else begin
            if (ba.frame_done === 1'b1) a_done++;
            if (ba.ack_nxt === 1'b0) begin
                if (a_present && !a_hold) begin
                    a_cnt++;
                    if (a_cnt >= 3) begin
                        ba.ack_nxt = 1'b1;
                        a_cnt      = 0;
                        a_t.push_back({ba.x0_t, ba.x1_t, ba.x2_t, ba.x3_t});
                        a_f.push_back({ba.x0_f, ba.x1_f, ba.x2_f, ba.x3_f});
                    end
                end else a_cnt = 0;
            end else begin
                if (!a_present) begin
                    a_cnt++;
                    if (a_cnt >= 3) begin
                        ba.ack_nxt = 1'b0;
                        a_cnt      = 0;
                    end
                end else a_cnt = 0;
            end
        end
    end

    always @(negedge clk) begin
        if (tb_rst) begin
            bb.ack_nxt = 1'b0;
            b_cnt      = 0;
        end else begin
            if (bb.frame_done === 1'b1) b_done++;
            if (bb.ack_nxt === 1'b0) begin
                if (b_present && !b_hold) begin
                    b_cnt++;
                    if (b_cnt >= 3) begin
                        bb.ack_nxt = 1'b1;
                        b_cnt      = 0;
                        b_t.push_back({bb.x0_t, bb.x1_t, bb.x2_t, bb.x3_t});
                        b_f.push_back({bb.x0_f, bb.x1_f, bb.x2_f, bb.x3_f});
                    end
                end else b_cnt = 0;
            end else begin
                if (!b_present) begin
                    b_cnt++;
                    if (b_cnt >= 3) begin
                        bb.ack_nxt = 1'b0;
                        b_cnt      = 0;
                    end
                end else b_cnt = 0;
            end
        end
    end

    task automatic push_a(input logic [7:0] px);
        int n = 0;
        @(negedge clk);
        ba.in_valid = 1'b1;
        ba.in_data  = px;
        while (ba.in_ready !== 1'b1 && n < 500) begin @(negedge clk); n++; end
        if (ba.in_ready !== 1'b1) begin
            errors++; checks++;
            $display("FAIL push_a_timeout px=%h in_ready=%b expected 1", px, ba.in_ready);
        end else @(posedge clk);
    endtask

    task automatic push_b(input logic [7:0] px);
        int n = 0;
        @(negedge clk);
        bb.in_valid = 1'b1;
        bb.in_data  = px;
        while (bb.in_ready !== 1'b1 && n < 500) begin @(negedge clk); n++; end
        if (bb.in_ready !== 1'b1) begin
            errors++; checks++;
            $display("FAIL push_b_timeout px=%h in_ready=%b expected 1", px, bb.in_ready);
        end else @(posedge clk);
    endtask

    task automatic wait_a(input int nwin, input int ndone);
        int n = 0;
        @(negedge clk);
        ba.in_valid = 1'b0;
        while ((a_t.size() < nwin || a_done < ndone) && n < 2000) begin @(negedge clk); n++; end
        if (n >= 2000) begin
            errors++; checks++;
            $display("FAIL wait_a_timeout windows=%0d done=%0d expected %0d/%0d", a_t.size(), a_done, nwin, ndone);
        end
        repeat (20) @(negedge clk);
    endtask

    task automatic wait_b(input int nwin, input int ndone);
        int n = 0;
        @(negedge clk);
        bb.in_valid = 1'b0;
        while ((b_t.size() < nwin || b_done < ndone) && n < 2000) begin @(negedge clk); n++; end
        if (n >= 2000) begin
            errors++; checks++;
            $display("FAIL wait_b_timeout windows=%0d done=%0d expected %0d/%0d", b_t.size(), b_done, nwin, ndone);
        end
        repeat (40) @(negedge clk);
    endtask

    task automatic test_reset();
        tb_rst = 1'b1;
        repeat (3) @(negedge clk);
        checks++; if (ba.in_ready !== 1'b0) begin errors++; $display("FAIL rst_in_ready got=%b exp=0", ba.in_ready); end
        checks++; if (a_present !== 1'b0) begin errors++; $display("FAIL rst_rails got=%b exp=0", a_present); end
        checks++; if (ba.frame_done !== 1'b0) begin errors++; $display("FAIL rst_frame_done got=%b exp=0", ba.frame_done); end
        tb_rst = 1'b0;
        @(negedge clk);
        checks++; if (ba.in_ready !== 1'b1) begin errors++; $display("FAIL idle_in_ready got=%b exp=1", ba.in_ready); end
        checks++; if (bb.in_ready !== 1'b1) begin errors++; $display("FAIL idle_in_ready_b got=%b exp=1", bb.in_ready); end
    endtask

    task automatic test_basic();
        int d0 = a_done;
        a_t.delete(); a_f.delete();
        for (int i = 1; i <= 6; i++) push_a(8'(i));
        #1;
        checks++; if (ba.x0_t !== 8'h01) begin errors++; $display("FAIL basic_latency_x0_t got=%h exp=01", ba.x0_t); end
        checks++; if (ba.x0_f !== 8'hFE) begin errors++; $display("FAIL basic_latency_x0_f got=%h exp=fe", ba.x0_f); end
        push_a(8'd7);
        push_a(8'd8);
        wait_a(2, d0 + 1);
        checks++; if (a_t.size() != 2) begin errors++; $display("FAIL basic_count got=%0d exp=2", a_t.size()); end
        if (a_t.size() >= 2) begin
            checks++; if (a_t[0] !== 32'h01020506) begin errors++; $display("FAIL basic_win1_t got=%h exp=01020506", a_t[0]); end
            checks++; if (a_f[0] !== 32'hFEFDFAF9) begin errors++; $display("FAIL basic_win1_f got=%h exp=fefdfaf9", a_f[0]); end
            checks++; if (a_t[1] !== 32'h03040708) begin errors++; $display("FAIL basic_win2_t got=%h exp=03040708", a_t[1]); end
            checks++; if (a_f[1] !== 32'hFCFBF8F7) begin errors++; $display("FAIL basic_win2_f got=%h exp=fcfbf8f7", a_f[1]); end
        end
        checks++; if (a_done - d0 != 1) begin errors++; $display("FAIL basic_frame_done got=%0d exp=1", a_done - d0); end
    endtask

    task automatic test_signed();
        logic [7:0] px [8] = '{8'h80, 8'h7F, 8'h01, 8'h02, 8'hFF, 8'h00, 8'h03, 8'h04};
        int d0 = a_done;
        a_t.delete(); a_f.delete();
        for (int i = 0; i < 6; i++) push_a(px[i]);
        #1;
        checks++; if (ba.x1_t !== 8'h7F || ba.x1_f !== 8'h80) begin errors++; $display("FAIL signed_x1 got=%h/%h exp=7f/80", ba.x1_t, ba.x1_f); end
        push_a(px[6]);
        push_a(px[7]);
        wait_a(2, d0 + 1);
        checks++; if (a_t.size() != 2) begin errors++; $display("FAIL signed_count got=%0d exp=2", a_t.size()); end
        if (a_t.size() >= 2) begin
            checks++; if (a_t[0] !== 32'h807FFF00) begin errors++; $display("FAIL signed_win_t got=%h exp=807fff00", a_t[0]); end
            checks++; if (a_f[0] !== 32'h7F8000FF) begin errors++; $display("FAIL signed_win_f got=%h exp=7f8000ff", a_f[0]); end
            checks++; if (a_t[1] !== 32'h01020304) begin errors++; $display("FAIL signed_win2_t got=%h exp=01020304", a_t[1]); end
        end
    endtask

    task automatic test_back_pressure();
        int d0 = a_done;
        int ready_hi = 0, rail_chg = 0;
        logic [63:0] snap;
        a_t.delete(); a_f.delete();
        a_hold = 1'b1;
        for (int i = 1; i <= 7; i++) push_a(8'(8'h20 + i));
        @(negedge clk);
        ba.in_data = 8'h28;
        snap = {ba.x0_t, ba.x0_f, ba.x1_t, ba.x1_f, ba.x2_t, ba.x2_f, ba.x3_t, ba.x3_f};
        for (int i = 0; i < 50; i++) begin
            @(negedge clk);
            if (ba.in_ready !== 1'b0) ready_hi++;
            if ({ba.x0_t, ba.x0_f, ba.x1_t, ba.x1_f, ba.x2_t, ba.x2_f, ba.x3_t, ba.x3_f} !== snap) rail_chg++;
        end
        checks++; if (snap !== 64'h21DE22DD25DA26D9) begin errors++; $display("FAIL bp_rails got=%h exp=21de22dd25da26d9", snap); end
        checks++; if (ready_hi != 0) begin errors++; $display("FAIL bp_in_ready_high cycles=%0d exp=0", ready_hi); end
        checks++; if (rail_chg != 0) begin errors++; $display("FAIL bp_rails_changed cycles=%0d exp=0", rail_chg); end
        a_hold = 1'b0;
        push_a(8'h28);
        wait_a(2, d0 + 1);
        checks++; if (a_t.size() != 2) begin errors++; $display("FAIL bp_count got=%0d exp=2", a_t.size()); end
        if (a_t.size() >= 2) begin
            checks++; if (a_t[0] !== 32'h21222526) begin errors++; $display("FAIL bp_win1 got=%h exp=21222526", a_t[0]); end
            checks++; if (a_t[1] !== 32'h23242728) begin errors++; $display("FAIL bp_win2 got=%h exp=23242728", a_t[1]); end
        end
    endtask

    task automatic test_reset_in_data();
        int d0;
        a_hold = 1'b1;
        for (int i = 1; i <= 6; i++) push_a(8'(8'h40 + i));
        @(negedge clk);
        ba.in_valid = 1'b0;
        checks++; if (ba.x0_t !== 8'h41) begin errors++; $display("FAIL rd_pre_x0 got=%h exp=41", ba.x0_t); end
        tb_rst = 1'b1;
        @(negedge clk);
        checks++; if (a_present !== 1'b0) begin errors++; $display("FAIL rd_rails got=%b exp=0", a_present); end
        checks++; if (ba.in_ready !== 1'b0) begin errors++; $display("FAIL rd_in_ready got=%b exp=0", ba.in_ready); end
        checks++; if (dut_a.col_q !== 2'd0 || dut_a.row_q !== 1'd0) begin
            errors++; $display("FAIL rd_counters got=%0d/%0d exp=0/0", dut_a.col_q, dut_a.row_q);
        end
        tb_rst = 1'b0;
        a_hold = 1'b0;
        a_t.delete(); a_f.delete();
        d0 = a_done;
        for (int i = 1; i <= 8; i++) push_a(8'(8'h30 + i));
        wait_a(2, d0 + 1);
        checks++; if (a_t.size() != 2) begin errors++; $display("FAIL rd_count got=%0d exp=2", a_t.size()); end
        if (a_t.size() >= 1) begin
            checks++; if (a_t[0] !== 32'h31323536) begin errors++; $display("FAIL rd_win1 got=%h exp=31323536", a_t[0]); end
        end
    endtask

    task automatic test_back_to_back();
        logic [31:0] exp_w [4] = '{32'h01020506, 32'h03040708, 32'h11121516, 32'h13141718};
        int d0 = a_done;
        a_t.delete(); a_f.delete();
        for (int i = 1; i <= 8; i++) push_a(8'(i));
        for (int i = 1; i <= 8; i++) push_a(8'(8'h10 + i));
        wait_a(4, d0 + 2);
        checks++; if (a_t.size() != 4) begin errors++; $display("FAIL b2b_count got=%0d exp=4", a_t.size()); end
        for (int i = 0; i < 4 && i < a_t.size(); i++) begin
            checks++;
            if (a_t[i] !== exp_w[i]) begin errors++; $display("FAIL b2b_win%0d got=%h exp=%h", i, a_t[i], exp_w[i]); end
        end
        checks++; if (a_done - d0 != 2) begin errors++; $display("FAIL b2b_frame_done got=%0d exp=2", a_done - d0); end
    endtask

    task automatic test_odd_width();
        int d0 = b_done;
        int exp_n;
`ifdef POOL_PAD_EN
        exp_n = 3;
`else
        exp_n = 2;
`endif
        b_t.delete(); b_f.delete();
        for (int i = 1; i <= 15; i++) push_b(8'(i));
        wait_b(exp_n, d0 + 1);
        checks++; if (b_t.size() != exp_n) begin errors++; $display("FAIL odd_count got=%0d exp=%0d", b_t.size(), exp_n); end
        if (b_t.size() >= 2) begin
            checks++; if (b_t[0] !== 32'h01020607) begin errors++; $display("FAIL odd_win1 got=%h exp=01020607", b_t[0]); end
            checks++; if (b_t[1] !== 32'h03040809) begin errors++; $display("FAIL odd_win2 got=%h exp=03040809", b_t[1]); end
        end
`ifdef POOL_PAD_EN
        if (b_t.size() >= 3) begin
            checks++; if (b_t[2] !== 32'h05800A80) begin errors++; $display("FAIL odd_pad_t got=%h exp=05800a80", b_t[2]); end
            checks++; if (b_f[2] !== 32'hFA7FF57F) begin errors++; $display("FAIL odd_pad_f got=%h exp=fa7ff57f", b_f[2]); end
        end
`endif
        checks++; if (b_done - d0 != 1) begin errors++; $display("FAIL odd_frame_done got=%0d exp=1", b_done - d0); end
    endtask

    initial begin
        tb_rst      = 1'b1;
        ba.in_valid = 1'b0;
        ba.in_data  = 8'h00;
        bb.in_valid = 1'b0;
        bb.in_data  = 8'h00;
        test_reset();
        test_basic();
        test_signed();
        test_back_pressure();
        test_reset_in_data();
        test_back_to_back();
        test_odd_width();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule

// File: doc/pool_window_gen.md
Name: pool_window_gen

Overview:
- Clocked front end for the 2x2 max-pool kernel.
- Accepts a raster-order pixel stream over a valid/ready interface and buffers one row.
- Forms non-overlapping 2x2 windows (stride 2).
- Presents each window as dual-rail (true/false rail) data using a four-phase return-to-zero handshake, completed by the kernel's acknowledge.

Parameters:
- BIT_DATA, 8, signed pixel width in bits.
- IMG_W, 16, feature-map width in pixels (>=2).
- IMG_H, 16, feature-map height in pixels (>=2).

Ports:
- clk  in  1  clock.
- reset  in  1  synchronous active-high reset.
- in_valid  in  1  pixel valid.
- in_ready  out  1  pixel accepted when in_valid & in_ready at rising clk.
- in_data  in  BIT_DATA  signed pixel, raster order, row 0 first.
- x0_t, x0_f  out  BIT_DATA each  top-left pixel, dual rail.
- x1_t, x1_f  out  BIT_DATA each  top-right pixel, dual rail.
- x2_t, x2_f  out  BIT_DATA each  bottom-left pixel, dual rail.
- x3_t, x3_f  out  BIT_DATA each  bottom-right pixel, dual rail.
- ack_nxt  in  1  acknowledge from kernel (asynchronous to clk).
- frame_done  out  1  one-cycle pulse when the last window of a frame returns to spacer.

Behaviour:
- Reset values (reset sampled high at clk edge): all x*_t/x*_f = 0 (spacer), in_ready = 0, frame_done = 0, col = row = 0, state = IDLE, synchronizer flops = 0. This applies mid-handshake too. The system resets the kernel together with this block.
- in_ready = 1 in IDLE. In DATA or NULL it is 1 only if the accepted pixel would not complete a new window.
- Counters: col increments per accepted pixel and wraps from IMG_W-1 to 0, then row increments. row wraps from IMG_H-1 to 0, starting a new frame.
- Even row: pixel is written to line buffer at index col.
- Odd row, even col: pixel is held in a bottom-left register.
- Odd row, odd col: window completes:
  - x0 = buf[col-1], x1 = buf[col], x2 = held pixel, x3 = in_data.
  - Window is captured into an output register.
- Odd IMG_H: the last row is consumed and produces no windows.
- ack_nxt passes through a 2-flop synchronizer to give ack_s.
- State machine:
  - IDLE: rails at spacer. On window capture, drive rails next cycle (t = value, f = ~value) and go to DATA.
  - DATA: hold rails. When ack_s = 1, drive all rails to 0 next cycle and go to NULL.
  - NULL: hold spacer. When ack_s = 0, go to IDLE. If this was the last window of the frame, pulse frame_done in the same cycle.
- Latency: rails valid 1 cycle after the completing pixel's handshake. Window-to-window minimum is 1 + sync delay (2) + kernel delays, per phase.
- Back-pressure: a completing pixel is stalled (in_ready = 0) while state != IDLE. Non-completing pixels keep flowing, so the line buffer continues filling during a handshake.
- Rails never hold mixed data/spacer values. All 8 rail words change on the same clk edge.
- ack_s = 1 while entering DATA: no shortcut; the transition to NULL occurs on the next evaluated edge in DATA.

Optional Feature:
- Macro POOL_PAD_EN.
- Defined, IMG_W odd: at odd row, col = IMG_W-1, a window completes with:
  - x0 = buf[IMG_W-1], x2 = in_data;
  - x1 = x3 = most negative value (1 followed by BIT_DATA-1 zeros).
  - Windows per frame = ceil(IMG_W/2) * floor(IMG_H/2).
- Not defined: the last odd column is consumed without a window. Windows per frame = floor(IMG_W/2) * floor(IMG_H/2).
- IMG_W even: behaviour is identical with or without the macro.

Test Plan:
- IMG_W = 4, IMG_H = 2, pixels 1..8, kernel model acks 3 cycles after data / spacer:
  - window 1: x0..x3 = 1, 2, 5, 6, with x0_f = ~1;
  - window 2: 3, 4, 7, 8;
  - frame_done pulses once after window 2 NULL.
- Signed values -128, 127, -1, 0 in one window: rails t = 0x80, 0x7F, 0xFF, 0x00; f = bitwise complements.
- ack_nxt held low for 50 cycles after window 1:
  - in_ready drops at the next completing pixel;
  - rails stay stable;
  - after ack, spacer then window 2 with no pixel lost.
- Reset asserted in DATA: next cycle all rails = 0, in_ready = 0, counters = 0; the following frame's first window is correct.
- IMG_W = 5, IMG_H = 3:
  - without POOL_PAD_EN: 2 windows;
  - with POOL_PAD_EN: 3 windows, the third being x1 = x3 = 0x80.
- Continuous in_valid across two frames: 2nd-frame windows use only 2nd-frame pixels; frame_done pulses twice.
